// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane helper used by
// the SRAM slave and its storage array.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slave_state_t;

  // Little-endian byte enables for a transfer of the given size at the given
  // byte offset within the word. Illegal sizes enable nothing.
  function automatic logic [3:0] lane_mask(input logic [2:0] hsize, input logic [1:0] addr);
    logic [3:0] mask;
    mask = 4'b0000;
    case (hsize)
      3'd0:    mask = 4'b0001 << addr;
      3'd1:    mask = addr[1] ? 4'b1100 : 4'b0011;
      3'd2:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised on-chip storage with per-byte write enables and an
// asynchronous read port. Contents are deliberately never reset.
module ahb_sram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Byte-lane write: lanes without an enable keep their previous contents
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite subordinate in front of a word-addressed SRAM. Inserts a fixed
// number of wait states on OKAY transfers and gives the two-cycle ERROR
// response for illegal sizes or misaligned addresses.
module ahb_lite_sram_slave
  import ahb_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int AW = $clog2(DEPTH);

  slave_state_t  r_state;
  slave_state_t  w_nextState;
  logic [3:0]    r_waitCnt;
  logic [3:0]    w_nextCnt;

  logic          r_dphActive;
  logic          r_write;
  logic [2:0]    r_size;
  logic [1:0]    r_byteOff;
  logic [AW-1:0] r_index;

  logic          w_readyOut;
  logic          w_accept;
  logic          w_illegal;
  logic          w_commit;
  logic [3:0]    w_we;
  logic [31:0]   w_rdata;
  logic          w_unused;

  // Burst type, protection, the non-decoded address bits and the low HTRANS
  // bit carry no meaning for this slave.
  assign w_unused = ^{HBURST, HPROT, HADDR[31:AW+2], HTRANS[0]};

  // Only IDLE and ERR2 end a data phase, so only they can take a new address
  assign w_readyOut = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign w_accept   = HSEL & HREADY & HTRANS[1] & w_readyOut;

  assign w_illegal = (HSIZE > HSIZE_WORD)
                   | ((HSIZE == HSIZE_HALF) & HADDR[0])
                   | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));

  // State register and wait-state counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_waitCnt <= 4'd0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextCnt;
    end
  end

  // Next-state logic; the counter is loaded with one less than the wait
  // count so WAIT lasts exactly WAIT_STATES cycles before the completion cycle
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_waitCnt;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_nextState = ST_IDLE;
        if (w_accept) begin
          if (w_illegal) begin
            w_nextState = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_nextState = ST_WAIT;
            w_nextCnt   = 4'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (r_waitCnt == 4'd0) begin
          w_nextState = ST_IDLE;
        end else begin
          w_nextCnt = r_waitCnt - 4'd1;
        end
      end
      ST_ERR1: w_nextState = ST_ERR2;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Data-phase bookkeeping: remember whether a legal transfer is in flight
  // and latch its control so the data phase can act on it later
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dphActive <= 1'b0;
      r_write     <= 1'b0;
      r_size      <= 3'd0;
      r_byteOff   <= 2'd0;
      r_index     <= '0;
    end else begin
      if (w_readyOut) begin
        r_dphActive <= w_accept & ~w_illegal;
      end
      if (w_accept) begin
        r_write   <= HWRITE;
        r_size    <= HSIZE;
        r_byteOff <= HADDR[1:0];
        r_index   <= HADDR[AW+1:2];
      end
    end
  end

  // A write lands on the edge that ends its OKAY data phase; reset on that
  // same edge abandons it
  assign w_commit = r_dphActive & r_write & (r_state == ST_IDLE) & ~reset;
  assign w_we     = w_commit ? lane_mask(r_size, r_byteOff) : 4'b0000;

  ahb_sram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (r_index),
    .i_wdata (HWDATA),
    .o_rdata (w_rdata)
  );

  assign HREADYOUT = w_readyOut;
  assign HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = (r_dphActive & ~r_write) ? w_rdata : 32'd0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Randomised and directed bench for the AHB-Lite SRAM slave. Two instances
// run side by side, one with no wait states and one with three, each checked
// against a transaction-level memory model.
module tb_ahb_lite_sram_slave;

  logic clk = 1'b0;
  logic reset;

  logic [1:0]       hsel, hwrite, hready, hreadyout, hresp;
  logic [1:0][1:0]  htrans;
  logic [1:0][2:0]  hsize;
  logic [1:0][31:0] haddr, hwdata, hrdata;
  logic [2:0]       hburst = 3'd0;
  logic [3:0]       hprot  = 4'd0;

  int errCount   = 0;
  int checkCount = 0;

  logic [31:0] refMem [2][256];

  always #5 clk = ~clk;

  // Each slave is alone on its bus, so the bus ready is its own ready
  assign hready = hreadyout;

  ahb_lite_sram_slave #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWDATA(hwdata[0]),
    .HWRITE(hwrite[0]), .HTRANS(htrans[0]), .HSIZE(hsize[0]), .HBURST(hburst),
    .HPROT(hprot), .HREADY(hready[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]),
    .HRDATA(hrdata[0])
  );

  ahb_lite_sram_slave #(.DEPTH(256), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset(reset), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWDATA(hwdata[1]),
    .HWRITE(hwrite[1]), .HTRANS(htrans[1]), .HSIZE(hsize[1]), .HBURST(hburst),
    .HPROT(hprot), .HREADY(hready[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]),
    .HRDATA(hrdata[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int waitStatesOf(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit isIllegal(input logic [2:0] sz, input logic [31:0] addr);
    return (sz > 3'd2) || (sz == 3'd1 && addr % 2 != 0) || (sz == 3'd2 && addr % 4 != 0);
  endfunction

  function automatic int wordIndex(input logic [31:0] addr);
    return int'((addr >> 2) % 256);
  endfunction

  // Reference write: the bytes covered by the transfer take the matching
  // bytes of the bus word; all others are untouched
  task automatic modelWrite(input int d, input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] data);
    int idx;
    int first;
    int nbytes;
    idx    = wordIndex(addr);
    first  = int'(addr % 4);
    nbytes = 1 << sz;
    for (int k = first; k < first + nbytes; k++) begin
      refMem[d][idx][8*k +: 8] = data[8*k +: 8];
    end
  endtask

  // One isolated transfer: address phase, then the full data phase, checking
  // handshake timing, response and read data along the way
  task automatic applyStimulus(input int d, input bit wr, input logic [2:0] sz,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata);
    int stalls;
    rdata     = 32'd0;
    hsel[d]   = 1'b1;
    htrans[d] = 2'b10;
    hwrite[d] = wr;
    hsize[d]  = sz;
    haddr[d]  = addr;
    step();
    hsel[d]   = 1'b0;
    htrans[d] = 2'b00;
    hwdata[d] = wdata;
    if (isIllegal(sz, addr)) begin
      checkOutput("err1Ready", hreadyout[d], 1'b0);
      checkOutput("err1Resp", hresp[d], 1'b1);
      step();
      checkOutput("err2Ready", hreadyout[d], 1'b1);
      checkOutput("err2Resp", hresp[d], 1'b1);
      checkOutput("errRdata", hrdata[d], 32'd0);
      step();
      checkOutput("errDoneReady", hreadyout[d], 1'b1);
      checkOutput("errDoneResp", hresp[d], 1'b0);
    end else begin
      stalls = 0;
      while (hreadyout[d] !== 1'b1 && stalls < 40) begin
        checkOutput("waitResp", hresp[d], 1'b0);
        step();
        stalls++;
      end
      checkOutput("stallCount", stalls, waitStatesOf(d));
      checkOutput("okayResp", hresp[d], 1'b0);
      rdata = hrdata[d];
      if (wr) begin
        checkOutput("writeRdata", hrdata[d], 32'd0);
      end else begin
        checkOutput("readData", hrdata[d], refMem[d][wordIndex(addr)]);
      end
      step();
      if (wr) begin
        modelWrite(d, sz, addr, wdata);
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] addr;
    logic [2:0]  sz;
    bit          wr;
    int          r;

    hsel = '0; hwrite = '0; htrans = '0; hsize = '0; haddr = '0; hwdata = '0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    for (int d = 0; d < 2; d++) begin
      checkOutput("resetReady", hreadyout[d], 1'b1);
      checkOutput("resetResp", hresp[d], 1'b0);
      checkOutput("resetRdata", hrdata[d], 32'd0);
    end

    // IDLE transfer with the slave selected: zero-wait OKAY
    hsel = 2'b11;
    htrans = '0;
    step();
    for (int d = 0; d < 2; d++) begin
      checkOutput("idleReady", hreadyout[d], 1'b1);
      checkOutput("idleResp", hresp[d], 1'b0);
    end
    hsel = '0;

    // Give every word the random section touches a known value
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        applyStimulus(d, 1'b1, 3'd2, 32'(i * 4), $urandom, rd);
      end
    end

    // Back-to-back write then read of the same word with no wait states
    hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; hsize[0] = 3'd2; haddr[0] = 32'h10;
    step();
    hwdata[0] = 32'hDEADBEEF;
    hwrite[0] = 1'b0;
    checkOutput("b2bWriteReady", hreadyout[0], 1'b1);
    step();
    modelWrite(0, 3'd2, 32'h10, 32'hDEADBEEF);
    hsel[0] = 1'b0; htrans[0] = 2'b00;
    checkOutput("b2bReadReady", hreadyout[0], 1'b1);
    checkOutput("b2bReadResp", hresp[0], 1'b0);
    checkOutput("b2bReadData", hrdata[0], 32'hDEADBEEF);
    step();

    // Byte and halfword merges into a cleared word
    applyStimulus(0, 1'b1, 3'd2, 32'h10, 32'h00000000, rd);
    applyStimulus(0, 1'b1, 3'd0, 32'h11, 32'h0000AA00, rd);
    applyStimulus(0, 0, 3'd2, 32'h10, 32'd0, rd);
    checkOutput("byteMerge", rd, 32'h0000AA00);
    applyStimulus(0, 1'b1, 3'd1, 32'h12, 32'h12340000, rd);
    applyStimulus(0, 0, 3'd2, 32'h10, 32'd0, rd);
    checkOutput("halfMerge", rd, 32'h1234AA00);

    // Illegal writes on both instances leave memory untouched
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, 1'b1, 3'd2, 32'h13, 32'hFFFFFFFF, rd);
      applyStimulus(d, 0, 3'd2, 32'h10, 32'd0, rd);
      applyStimulus(d, 1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, rd);
      applyStimulus(d, 0, 3'd2, 32'h10, 32'd0, rd);
    end

    // Reset during the second wait cycle of a write abandons it
    applyStimulus(1, 1'b1, 3'd2, 32'h20, 32'hCAFEF00D, rd);
    hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; hsize[1] = 3'd2; haddr[1] = 32'h20;
    step();
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'h0BADC0DE;
    checkOutput("abortWait1", hreadyout[1], 1'b0);
    step();
    checkOutput("abortWait2", hreadyout[1], 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("abortReady", hreadyout[1], 1'b1);
    checkOutput("abortResp", hresp[1], 1'b0);
    checkOutput("abortRdata", hrdata[1], 32'd0);
    applyStimulus(1, 0, 3'd2, 32'h20, 32'd0, rd);
    checkOutput("abortOldData", rd, 32'hCAFEF00D);

    // Random mix of sizes, alignments and don't-care upper address bits
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        wr   = 1'($urandom_range(0, 1));
        r    = int'($urandom_range(0, 9));
        sz   = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'(4 + $urandom_range(0, 3));
        addr = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
        applyStimulus(d, wr, sz, addr, $urandom, rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
